// File: rtl/ppc_uop_sequencer.sv
// ppc_uop_sequencer
// Decode-side micro-op sequencer. Accepts one architectural instruction per
// valid/ready handshake and issues single-effect micro-ops downstream:
//   - D-form load/store with update -> base access + addi RA,RA,D
//   - lmw / stmw                     -> lwz / stw sequence up to r31
//   - everything else                -> passed through unchanged
// Optional feature macro: UOP_XFORM_UPDATE_EN
//   When defined, OPCD 31 X-form update loads/stores are split into the
//   indexed base access + add RA,RA,RB as well.
// Instruction fields use PPC bit numbering (bit 0 = MSB), so OPCD [0:5]
// maps to in_insn[31:26], RT [6:10] to [25:21], RA [11:15] to [20:16],
// D [16:31] to [15:0], RB [16:20] to [15:11], XO [21:30] to [10:1].

module ppc_uop_sequencer #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_insn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_insn,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic                   out_last,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UPD  = 2'd1,
    S_MW   = 2'd2
  } state_t;

  localparam logic [5:0] OP_ADDI = 6'd14;
  localparam logic [5:0] OP_LWZ  = 6'd32;
  localparam logic [5:0] OP_STW  = 6'd36;
  localparam logic [5:0] OP_STMW = 6'd47;
`ifdef UOP_XFORM_UPDATE_EN
  localparam logic [5:0] OP_X31  = 6'd31;
  localparam logic [8:0] XO_ADD  = 9'd266;
`endif

  // Registered state
  state_t                   r_state;
  logic [4:0]               r_rt;
  logic [15:0]              r_d;      // offset for lmw/stmw and D-update; RB for X-update
  logic [4:0]               r_ra;
  logic                     r_is_st;  // sequence is stmw (stw) rather than lmw (lwz)
`ifdef UOP_XFORM_UPDATE_EN
  logic                     r_xupd;   // UPD finishes with add RA,RA,RB instead of addi
`endif
  logic                     r_out_valid;
  logic [INSTR_WIDTH-1:0]   r_out_insn;
  logic [PC_WIDTH-1:0]      r_out_pc;
  logic                     r_out_last;

  // Next-state values
  state_t                   w_state_nxt;
  logic [4:0]               w_rt_nxt;
  logic [15:0]              w_d_nxt;
  logic [4:0]               w_ra_nxt;
  logic                     w_is_st_nxt;
`ifdef UOP_XFORM_UPDATE_EN
  logic                     w_xupd_nxt;
`endif
  logic                     w_out_valid_nxt;
  logic [INSTR_WIDTH-1:0]   w_out_insn_nxt;
  logic [PC_WIDTH-1:0]      w_out_pc_nxt;
  logic                     w_out_last_nxt;

  // Decode of the offered instruction
  logic                     w_adv;
  logic                     w_accept;
  logic [5:0]               w_opcd;
  logic [4:0]               w_rt;
  logic [4:0]               w_ra;
  logic [15:0]              w_d;
  logic                     w_is_dupd;
  logic                     w_is_mw;
`ifdef UOP_XFORM_UPDATE_EN
  logic [9:0]               w_xo;
  logic                     w_is_xupd;
`endif

  assign w_opcd    = in_insn[31:26];
  assign w_rt      = in_insn[25:21];
  assign w_ra      = in_insn[20:16];
  assign w_d       = in_insn[15:0];
  assign w_is_dupd = w_opcd inside {6'd33, 6'd35, 6'd37, 6'd39, 6'd41, 6'd43, 6'd45};
  assign w_is_mw   = w_opcd inside {6'd46, 6'd47};
`ifdef UOP_XFORM_UPDATE_EN
  assign w_xo      = in_insn[10:1];
  assign w_is_xupd = (w_opcd == OP_X31) &&
                     (w_xo inside {10'd55, 10'd119, 10'd311, 10'd375, 10'd183, 10'd247, 10'd439});
`endif

  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = !rst && (r_state == S_IDLE) && w_adv && !flush;
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign out_insn  = r_out_insn;
  assign out_pc    = r_out_pc;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);

  // Next-state and next-output logic: flush wins, otherwise advance only when
  // the current micro-op is gone (or there is none); else everything holds.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    w_state_nxt     = r_state;
    w_rt_nxt        = r_rt;
    w_d_nxt         = r_d;
    w_ra_nxt        = r_ra;
    w_is_st_nxt     = r_is_st;
`ifdef UOP_XFORM_UPDATE_EN
    w_xupd_nxt      = r_xupd;
`endif
    w_out_valid_nxt = r_out_valid;
    w_out_insn_nxt  = r_out_insn;
    w_out_pc_nxt    = r_out_pc;
    w_out_last_nxt  = r_out_last;

    if (flush) begin
      w_state_nxt     = S_IDLE;
      w_rt_nxt        = 5'd0;
      w_d_nxt         = 16'd0;
      w_out_valid_nxt = 1'b0;
    end else if (w_adv) begin
      unique case (r_state)
        S_IDLE: begin
          w_out_valid_nxt = 1'b0;
          if (w_accept) begin
            w_out_valid_nxt = 1'b1;
            w_out_pc_nxt    = in_pc;
            w_out_insn_nxt  = in_insn;
            w_out_last_nxt  = 1'b1;
            if (w_is_dupd) begin
              // Base opcode of each D-update form is one below it.
              w_out_insn_nxt = {w_opcd - 6'd1, in_insn[25:0]};
              w_out_last_nxt = 1'b0;
              w_ra_nxt       = w_ra;
              w_d_nxt        = w_d;
`ifdef UOP_XFORM_UPDATE_EN
              w_xupd_nxt     = 1'b0;
`endif
              w_state_nxt    = S_UPD;
            end else if (w_is_mw) begin
              w_out_insn_nxt = {(w_opcd == OP_STMW) ? OP_STW : OP_LWZ, in_insn[25:0]};
              if (w_rt != 5'd31) begin
                w_out_last_nxt = 1'b0;
                w_rt_nxt       = w_rt + 5'd1;
                w_d_nxt        = w_d + 16'd4;
                w_ra_nxt       = w_ra;
                w_is_st_nxt    = (w_opcd == OP_STMW);
                w_state_nxt    = S_MW;
              end
`ifdef UOP_XFORM_UPDATE_EN
            end else if (w_is_xupd) begin
              // Indexed base XO is the update XO minus 32; Rc forced to 0.
              w_out_insn_nxt = {in_insn[31:11], w_xo - 10'd32, 1'b0};
              w_out_last_nxt = 1'b0;
              w_ra_nxt       = w_ra;
              w_d_nxt        = {11'd0, in_insn[15:11]};
              w_xupd_nxt     = 1'b1;
              w_state_nxt    = S_UPD;
`endif
            end
          end
        end

        S_UPD: begin
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = 1'b1;
          w_out_insn_nxt  = {OP_ADDI, r_ra, r_ra, r_d};
`ifdef UOP_XFORM_UPDATE_EN
          if (r_xupd) begin
            w_out_insn_nxt = {OP_X31, r_ra, r_ra, r_d[4:0], 1'b0, XO_ADD, 1'b0};
          end
`endif
          w_state_nxt     = S_IDLE;
        end

        S_MW: begin
          w_out_valid_nxt = 1'b1;
          w_out_insn_nxt  = {r_is_st ? OP_STW : OP_LWZ, r_rt, r_ra, r_d};
          w_out_last_nxt  = (r_rt == 5'd31);
          w_rt_nxt        = r_rt + 5'd1;
          w_d_nxt         = r_d + 16'd4;   // wraps modulo 2^16
          if (r_rt == 5'd31) begin
            w_state_nxt = S_IDLE;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset to the idle, empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rt        <= 5'd0;
      r_d         <= 16'd0;
      r_ra        <= 5'd0;
      r_is_st     <= 1'b0;
`ifdef UOP_XFORM_UPDATE_EN
      r_xupd      <= 1'b0;
`endif
      r_out_valid <= 1'b0;
      r_out_insn  <= '0;
      r_out_pc    <= '0;
      r_out_last  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_nxt;
      r_rt        <= w_rt_nxt;
      r_d         <= w_d_nxt;
      r_ra        <= w_ra_nxt;
      r_is_st     <= w_is_st_nxt;
`ifdef UOP_XFORM_UPDATE_EN
      r_xupd      <= w_xupd_nxt;
`endif
      r_out_valid <= w_out_valid_nxt;
      r_out_insn  <= w_out_insn_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

endmodule

// File: tb/tb_ppc_uop_sequencer.sv
// Self-checking bench for ppc_uop_sequencer. A reference model expands every
// accepted instruction into its full list of expected micro-ops (queue); the
// DUT outputs are compared against the queue head each cycle, and handshake
// outputs are derived from how many micro-ops remain outstanding.
// Honours UOP_XFORM_UPDATE_EN the same way the design does.

module tb_ppc_uop_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_insn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_pc;
  logic        out_last;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic        last;
  } uop_t;

  uop_t q[$];  // expected micro-ops not yet consumed; head is on out_*

  ppc_uop_sequencer #(.PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_insn   (in_insn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_pc    (out_pc),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_uop(input logic [31:0] i, input logic [31:0] p, input logic l);
    uop_t u;
    u.insn = i;
    u.pc   = p;
    u.last = l;
    q.push_back(u);
  endtask

  // Reference expansion of one architectural instruction into micro-ops.
  task automatic expand(input logic [31:0] insn, input logic [31:0] pc);
    int          opcd;
    int          rt;
    logic [4:0]  ra;
    logic [15:0] d;
    logic [15:0] dd;
    logic [5:0]  base;
`ifdef UOP_XFORM_UPDATE_EN
    int          xo;
    int          bx;
    logic [9:0]  bxv;
`endif
    opcd = int'(insn[31:26]);
    rt   = int'(insn[25:21]);
    ra   = insn[20:16];
    d    = insn[15:0];
`ifdef UOP_XFORM_UPDATE_EN
    xo = int'(insn[10:1]);
    case (xo)
      55:      bx = 23;
      119:     bx = 87;
      311:     bx = 279;
      375:     bx = 343;
      183:     bx = 151;
      247:     bx = 215;
      439:     bx = 407;
      default: bx = -1;
    endcase
`endif
    case (opcd)
      33: base = 6'd32;
      35: base = 6'd34;
      37: base = 6'd36;
      39: base = 6'd38;
      41: base = 6'd40;
      43: base = 6'd42;
      45: base = 6'd44;
      46: base = 6'd32;
      47: base = 6'd36;
      default: base = 6'd0;
    endcase
    if (opcd >= 33 && opcd <= 45 && (opcd % 2) == 1) begin
      push_uop({base, insn[25:0]}, pc, 1'b0);
      push_uop({6'd14, ra, ra, d}, pc, 1'b1);
    end else if (opcd == 46 || opcd == 47) begin
      for (int r = rt; r <= 31; r++) begin
        dd = d + 16'(4 * (r - rt));
        push_uop({base, 5'(r), ra, dd}, pc, r == 31);
      end
`ifdef UOP_XFORM_UPDATE_EN
    end else if (opcd == 31 && bx >= 0) begin
      bxv = 10'(bx);
      push_uop({insn[31:11], bxv, 1'b0}, pc, 1'b0);
      push_uop({6'd31, ra, ra, insn[15:11], 1'b0, 9'd266, 1'b0}, pc, 1'b1);
`endif
    end else begin
      push_uop(insn, pc, 1'b1);
    end
  endtask

  // One clock: drive inputs, check outputs on the falling edge, then advance
  // the model across the rising edge. Returns whether the offer was accepted.
  task automatic cycle(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                       input logic ordy, input logic fl, output logic acc);
    logic exp_ir;
    logic cons;
    in_valid  = v;
    in_insn   = insn;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    if (fl)                exp_ir = 1'b0;
    else if (q.size() == 0) exp_ir = 1'b1;
    else if (q.size() == 1) exp_ir = ordy;
    else                   exp_ir = 1'b0;
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, q.size() > 0);
    check("busy", busy, q.size() > 1);
    if (q.size() > 0) begin
      check("out_insn", out_insn, q[0].insn);
      check("out_pc", out_pc, q[0].pc);
      check("out_last", out_last, q[0].last);
    end
    acc  = v && exp_ir;
    cons = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (cons) void'(q.pop_front());
      if (acc) expand(insn, pc);
    end
    #1;
  endtask

  task automatic send(input logic [31:0] insn, input logic [31:0] pc);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) cycle(1'b1, insn, pc, 1'b1, 1'b0, acc);
    check("send_accept", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 64 && q.size() > 0; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("drain_out_valid", out_valid, 1'b0);
  endtask

  function automatic logic [31:0] gen_insn();
    int          k;
    logic [5:0]  op;
    logic [9:0]  xo;
    int          dupd[7] = '{33, 35, 37, 39, 41, 43, 45};
    int          xupd[7] = '{55, 119, 311, 375, 183, 247, 439};
    logic [31:0] r;
    r = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      1: begin
        op = 6'(dupd[$urandom_range(0, 6)]);
        r  = {op, r[25:0]};
      end
      2: begin
        op = ($urandom_range(0, 1) == 1) ? 6'd47 : 6'd46;
        r  = {op, 5'($urandom_range(24, 31)), r[20:0]};
      end
      3: begin
        xo = ($urandom_range(0, 3) == 0) ? r[10:1] : 10'(xupd[$urandom_range(0, 6)]);
        r  = {6'd31, r[25:11], xo, r[0]};
      end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic acc;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 32'h0;
    in_insn   = 32'h0;
    out_ready = 1'b1;

    // Reset values
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_insn", out_insn, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Pass-through and back-to-back stream
    send(32'h38600005, 32'h0000_0100);
    check("tp1_insn", out_insn, 32'h38600005);
    check("tp1_last", out_last, 1'b1);
    check("tp1_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'h38600000 | 32'(i), 32'h104 + 32'(4 * i), 1'b1, 1'b0, acc);
      check("tp1_b2b_accept", acc, 1'b1);
    end
    drain();

    // lwzu r3,8(r4)
    send(32'h84640008, 32'h0000_0200);
    check("tp2_uop0", out_insn, 32'h80640008);
    check("tp2_last0", out_last, 1'b0);
    check("tp2_in_ready_upd", in_ready, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("tp2_uop1", out_insn, 32'h38840008);
    check("tp2_last1", out_last, 1'b1);
    check("tp2_pc1", out_pc, 32'h0000_0200);
    drain();

    // lmw r29,0(r1) with three cycles of backpressure on the first micro-op
    send(32'hBBA10000, 32'h0000_0300);
    check("tp3_uop0", out_insn, 32'h83A10000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    check("tp5_bp_hold", out_insn, 32'h83A10000);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("tp3_uop1", out_insn, 32'h83C10004);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("tp3_uop2", out_insn, 32'h83E10008);
    check("tp3_last2", out_last, 1'b1);
    check("tp3_busy_fall", busy, 1'b0);
    drain();

    // stmw r31,-4(r1): single micro-op
    send(32'hBFE1FFFC, 32'h0000_0400);
    check("tp4_uop", out_insn, 32'h93E1FFFC);
    check("tp4_last", out_last, 1'b1);
    check("tp4_busy", busy, 1'b0);
    drain();

    // Offset wrap: lmw r28,0x7FF8(r2) crosses 0x7FFC -> 0x8000
    send(32'hBB827FF8, 32'h0000_0480);
    drain();

    // Flush mid-lmw
    send(32'hBA810010, 32'h0000_0500);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h38600001, 32'h504, 1'b0, 1'b1, acc);
    check("tp5_flush_valid", out_valid, 1'b0);
    check("tp5_flush_busy", busy, 1'b0);
    drain();

    // Asynchronous reset mid-lmw
    send(32'hBB210020, 32'h0000_0600);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("tp5_arst_valid", out_valid, 1'b0);
    check("tp5_arst_insn", out_insn, 32'h0);
    check("tp5_arst_pc", out_pc, 32'h0);
    check("tp5_arst_last", out_last, 1'b0);
    check("tp5_arst_busy", busy, 1'b0);
    q.delete();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("tp5_arst_in_ready", in_ready, 1'b1);

    // lwzux r3,r4,r5
    send(32'h7C64286E, 32'h0000_0700);
`ifdef UOP_XFORM_UPDATE_EN
    check("tp6_uop0", out_insn, 32'h7C64282E);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("tp6_uop1", out_insn, 32'h7C842A14);
`else
    check("tp6_pass", out_insn, 32'h7C64286E);
    check("tp6_last", out_last, 1'b1);
`endif
    drain();

    // Randomized traffic with backpressure and occasional flush
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 9) < 7, gen_insn(), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, acc);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ppc_uop_sequencer.md
# ppc_uop_sequencer

Decode-side micro-op sequencer for the PPC core. It sits between fetch and decode, accepts one architectural instruction per valid/ready handshake, and issues one or more single-effect micro-ops downstream. D-form load/store-with-update splits into access + `addi`. `lmw`/`stmw` expands into a `lwz`/`stw` sequence. Every other instruction passes through unchanged. The block owns the sequencing state (FSM, register/offset counters), so fetch only sees `in_ready`.

## Interface
- `PC_WIDTH`, 32, instruction address width
- `INSTR_WIDTH`, 32, instruction width; bit 0 = MSB (PPC numbering)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous; discard in-flight sequence
- `in_valid`  in  1  fetch offers `in_insn`/`in_pc`
- `in_ready`  out  1  sequencer accepts this cycle
- `in_pc`  in  PC_WIDTH  address of offered instruction
- `in_insn`  in  INSTR_WIDTH  offered instruction
- `out_valid`  out  1  micro-op present
- `out_ready`  in  1  decode consumes micro-op
- `out_insn`  out  INSTR_WIDTH  micro-op encoding
- `out_pc`  out  PC_WIDTH  PC of originating instruction, same on every micro-op of a sequence
- `out_last`  out  1  final micro-op of its instruction
- `busy`  out  1  state != IDLE

## Operation
- `adv = !out_valid || out_ready`.
- `in_ready = (state==IDLE) && adv && !flush`.
- FSM has three states: IDLE, UPD, MW.
- IDLE, on accept (`in_valid && in_ready`), decoded from `in_insn[0:5]`:
  - D-update (OPCD 33 lwzu, 35 lbzu, 37 stwu, 39 stbu, 41 lhzu, 43 lhau, 45 sthu):
    - Issue the base form with the same RT/RS, RA, D. Base opcodes: 32, 34, 36, 38, 40, 42, 44 respectively.
    - Set `out_last=0`, save RA and D, go to UPD.
  - lmw (46) / stmw (47):
    - Issue lwz (32) / stw (36) with RT, RA, D.
    - If RT==31: `out_last=1`, stay IDLE.
    - Otherwise: `rt_r=RT+1`, `d_r=D+4`, latch kind and RA, go to MW.
  - Anything else: issue `in_insn` unchanged, `out_last=1`.
- UPD, when `adv`:
  - Issue `addi` RA,RA,D (OPCD 14), `out_last=1`, go to IDLE.
- MW, when `adv`:
  - Issue lwz/stw `rt_r`,RA,`d_r`; then `rt_r+=1`, `d_r+=4`.
  - If `rt_r==31`: `out_last=1`, go to IDLE.
- An lmw/stmw with RT=n produces 32−n micro-ops. A D-update produces exactly 2.
- Arithmetic:
  - `rt_r` is 5 bits.
  - `d_r` is 16 bits, modulo 2^16 (0x7FFC+4 → 0x8000; no detection).
- Invalid forms are not checked; they are sequenced as normal. This covers RA==0 or RA==RT on update forms, and RA inside the lmw range.
- `flush` (above all except `rst`):
  - Next edge: `out_valid=0`, state IDLE, counters cleared.
  - `in_ready=0` in the flush cycle.

## Timing
- Reset values:
  - `out_valid=0`, `out_insn=0`, `out_pc=0`, `out_last=0`.
  - state IDLE, `busy=0`.
  - `rt_r=0`, `d_r=0`.
  - `in_ready` is combinational and goes to 1 once `rst` deasserts.
- Latency: instruction accepted at edge N appears at `out_*` after edge N. Follow-on micro-ops appear one per edge on which `adv` is true.
- Throughput: 1 pass-through instruction per cycle with `out_ready` held high.
- Backpressure: while `out_valid && !out_ready`, all `out_*` and internal state hold.
- `rst` mid-sequence: immediate return to reset values; the partial sequence is lost.
- `flush` and accept cannot coincide, because `in_ready` is forced low.

## Configuration
- `UOP_XFORM_UPDATE_EN`.
- Defined: OPCD 31 X-form update ops are split as well:
  - Recognised XO values: 55 lwzux, 119 lbzux, 311 lhzux, 375 lhaux, 183 stwux, 247 stbux, 439 sthux.
  - First micro-op: indexed base (XO 23, 87, 279, 343, 151, 215, 407), same RT/RS, RA, RB, Rc=0.
  - Second micro-op: `add` RA,RA,RB (OPCD 31, OE=0, XO 266, Rc=0), `out_last=1`.
  - UPD holds RB instead of D.
- Undefined: those instructions pass through as single micro-ops.

## Test plan
1. Pass-through: `addi` 0x38600005 with `out_ready=1` → next cycle `out_insn=0x38600005`, `out_last=1`, `in_ready=1`; back-to-back stream at 1/cycle.
2. lwzu r3,8(r4) 0x84640008 → micro-op 0x80640008 (`out_last=0`), then 0x38840008 (`out_last=1`); both carry `out_pc` of the lwzu; `in_ready=0` during UPD.
3. lmw r29,0(r1) 0xBBA10000 → 0x83A10000, 0x83C10004, 0x83E10008; `out_last` only on the third; `busy` falls after it.
4. stmw r31,−4(r1) 0xBFE1FFFC → single 0x93E1FFFC, `out_last=1`, state stays IDLE.
5. Backpressure/flush:
   - `out_ready=0` for 3 cycles mid-lmw → `out_insn` stable, no micro-op skipped.
   - `flush` mid-lmw → `out_valid=0` next cycle, `busy=0`.
   - `rst` pulse mid-sequence → all outputs return to reset values asynchronously.
6. With `UOP_XFORM_UPDATE_EN`: lwzux r3,r4,r5 0x7C64286E → 0x7C64282E then 0x7C842A14. Without the macro: single 0x7C64286E.
